// File: rtl/edulent_pkg.sv
// Shared types for the EDULENT datapath: transfer commands, SP strobe decode and memory FSM states.
package edulent_pkg;

  typedef enum logic [3:0] {
    CMD_NOP    = 4'h0,
    CMD_MA_PC  = 4'h1,
    CMD_MEM_RD = 4'h2,
    CMD_IR_MD  = 4'h3,
    CMD_MA_MD  = 4'h4,
    CMD_A_MD   = 4'h5,
    CMD_MA_AP  = 4'h6,
    CMD_MA_SP  = 4'h7,
    CMD_MD_A   = 4'h8,
    CMD_MEM_WR = 4'h9,
    CMD_A_R    = 4'hA,
    CMD_PC_MD  = 4'hB,
    CMD_A_IN   = 4'hC,
    CMD_OUT_A  = 4'hD,
    CMD_PC_AP  = 4'hE,
    CMD_MD_PC  = 4'hF
  } transfer_cmd_t;

  typedef enum logic [1:0] {
    SP_HOLD = 2'b00,
    SP_INC  = 2'b01,
    SP_DEC  = 2'b10
  } sp_op_t;

  typedef enum logic [1:0] {
    MEM_IDLE    = 2'd0,
    MEM_RD_WAIT = 2'd1,
    MEM_WR_WAIT = 2'd2
  } mem_state_t;

  // Both strobes at once is contradictory and is treated as hold.
  function automatic sp_op_t decode_sp_op(input logic [1:0] strobe);
    case (strobe)
      2'b01:   return SP_INC;
      2'b10:   return SP_DEC;
      default: return SP_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/edulent_mem_if.sv
// Req/ack memory handshake for the EDULENT datapath; request fields are held stable until ack.
module edulent_mem_if
  import edulent_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start_rd,
  input  logic              i_start_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_rd_load,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  mem_state_t state;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= MEM_IDLE;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (i_start_rd) begin
            state      <= MEM_RD_WAIT;
            o_mem_req  <= 1'b1;
            o_mem_we   <= 1'b0;
            o_mem_addr <= i_addr;
          end else if (i_start_wr) begin
            state       <= MEM_WR_WAIT;
            o_mem_req   <= 1'b1;
            o_mem_we    <= 1'b1;
            o_mem_addr  <= i_addr;
            o_mem_wdata <= i_wdata;
          end
        end
        MEM_RD_WAIT, MEM_WR_WAIT: begin
          if (i_mem_ack) begin
            state     <= MEM_IDLE;
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
          end
        end
        default: begin
          state     <= MEM_IDLE;
          o_mem_req <= 1'b0;
          o_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  // An ack seen in IDLE never reaches MD because the load strobe is qualified by RD_WAIT.
  assign o_busy    = (state != MEM_IDLE);
  assign o_rd_load = (state == MEM_RD_WAIT) && i_mem_ack;
  assign o_rd_data = i_mem_rdata;

endmodule

// File: rtl/edulent_datapath.sv
// EDULENT register-transfer datapath: one transfer command per cycle plus PC/SP strobes.
// Define EDULENT_SP_BOUNDS_EN to add a sticky o_sp_fault and make SP saturate at its limits.
module edulent_datapath
  import edulent_pkg::*;
#(
  parameter int                DATA_W  = 8,
  parameter int                ADDR_W  = 8,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}},
  parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [3:0]        i_transfer_cmd,
  input  logic              i_sel_ap,
  input  logic              i_inc_pc,
  input  logic [1:0]        i_inc_dec_sp,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_in_data,
  output logic [DATA_W-1:0] o_ir,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_md,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  output logic              o_busy,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata
`ifdef EDULENT_SP_BOUNDS_EN
  ,
  output logic              o_sp_fault
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] ma, pc, sp, sp_next;
  logic [DATA_W-1:0] md, ir, a, ap, out_data, rd_data;
  logic              out_valid, busy, rd_load, inc_pc;
  transfer_cmd_t     cmd;
  sp_op_t            sp_op;

  function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] d);
    logic [ADDR_W+DATA_W-1:0] w;
    w = {{ADDR_W{1'b0}}, d};
    return w[ADDR_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] to_data(input logic [ADDR_W-1:0] ad);
    logic [ADDR_W+DATA_W-1:0] w;
    w = {{DATA_W{1'b0}}, ad};
    return w[DATA_W-1:0];
  endfunction

  // While an access is pending the control unit's requests are squashed to no-ops.
  assign cmd    = busy ? CMD_NOP : transfer_cmd_t'(i_transfer_cmd);
  assign inc_pc = i_inc_pc & ~busy;
  assign sp_op  = busy ? SP_HOLD : decode_sp_op(i_inc_dec_sp);

`ifdef EDULENT_SP_BOUNDS_EN
  logic sp_fault, sp_fault_set;
`endif

  always_comb begin
    sp_next = sp;
    case (sp_op)
      SP_INC:  sp_next = sp + ADDR_ONE;
      SP_DEC:  sp_next = sp - ADDR_ONE;
      default: sp_next = sp;
    endcase
`ifdef EDULENT_SP_BOUNDS_EN
    sp_fault_set = ((sp_op == SP_INC) && (sp == '1)) || ((sp_op == SP_DEC) && (sp == '0));
    if (sp_fault_set) sp_next = sp;
`endif
  end

  // Later assignments win, so a PC load in the case statement overrides the increment.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ma        <= '0;
      md        <= '0;
      ir        <= '0;
      a         <= '0;
      ap        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      pc        <= PC_INIT;
      sp        <= SP_INIT;
    end else begin
      out_valid <= 1'b0;
      sp        <= sp_next;
      if (rd_load) md <= rd_data;
      if (inc_pc) pc <= pc + ADDR_ONE;
      case (cmd)
        CMD_MA_PC: ma <= pc;
        CMD_IR_MD: ir <= md;
        CMD_MA_MD: ma <= to_addr(md);
        CMD_A_MD:  if (i_sel_ap) ap <= md; else a <= md;
        CMD_MA_AP: ma <= to_addr(ap);
        CMD_MA_SP: ma <= sp;
        CMD_MD_A:  md <= i_sel_ap ? ap : a;
        CMD_A_R:   if (i_sel_ap) ap <= i_alu_result; else a <= i_alu_result;
        CMD_PC_MD: pc <= to_addr(md);
        CMD_A_IN:  a <= i_in_data;
        CMD_OUT_A: begin
          out_data  <= a;
          out_valid <= 1'b1;
        end
        CMD_PC_AP: pc <= to_addr(ap);
        CMD_MD_PC: md <= to_data(pc);
        default: ;
      endcase
    end
  end

`ifdef EDULENT_SP_BOUNDS_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) sp_fault <= 1'b0;
    else if (sp_fault_set) sp_fault <= 1'b1;
  end

  assign o_sp_fault = sp_fault;
`endif

  edulent_mem_if #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem_if (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_start_rd  (cmd == CMD_MEM_RD),
    .i_start_wr  (cmd == CMD_MEM_WR),
    .i_addr      (ma),
    .i_wdata     (md),
    .o_busy      (busy),
    .o_rd_load   (rd_load),
    .o_rd_data   (rd_data),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata)
  );

  assign o_ir        = ir;
  assign o_a         = a;
  assign o_md        = md;
  assign o_out_data  = out_data;
  assign o_out_valid = out_valid;
  assign o_busy      = busy;

endmodule

// File: tb/tb_edulent_datapath.sv
// Bench for edulent_datapath: directed scenarios then random commands against an arithmetic model.
module tb_edulent_datapath;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int AMOD   = 256;
`ifdef EDULENT_SP_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_rstn = 1'b0;
  logic [3:0]        i_transfer_cmd = '0;
  logic              i_sel_ap = 1'b0, i_inc_pc = 1'b0, i_mem_ack = 1'b0;
  logic [1:0]        i_inc_dec_sp = '0;
  logic [DATA_W-1:0] i_alu_result = '0, i_in_data = '0, i_mem_rdata = '0;
  logic [DATA_W-1:0] o_ir, o_a, o_md, o_out_data, o_mem_wdata;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_out_valid, o_busy, o_mem_req, o_mem_we;
`ifdef EDULENT_SP_BOUNDS_EN
  logic              o_sp_fault;
`endif

  edulent_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_transfer_cmd(i_transfer_cmd), .i_sel_ap(i_sel_ap),
    .i_inc_pc(i_inc_pc), .i_inc_dec_sp(i_inc_dec_sp), .i_alu_result(i_alu_result),
    .i_in_data(i_in_data), .o_ir(o_ir), .o_a(o_a), .o_md(o_md), .o_out_data(o_out_data),
    .o_out_valid(o_out_valid), .o_busy(o_busy), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata)
`ifdef EDULENT_SP_BOUNDS_EN
    , .o_sp_fault(o_sp_fault)
`endif
  );

  always #5 i_clk = ~i_clk;

  int compared = 0;
  int mismatched = 0;

  // Architectural state of the machine, tracked as plain integers modulo 256.
  int m_ma, m_md, m_ir, m_a, m_ap, m_pc, m_sp, m_out;
  bit m_out_valid, m_busy, m_rd, m_fault;
  int mem [AMOD];

  int ack_delay = 0;
  int req_cycles = 0;
  bit allow_spurious = 1'b0;
  bit rand_delay = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_ma = 0; m_md = 0; m_ir = 0; m_a = 0; m_ap = 0; m_out = 0;
    m_pc = 0; m_sp = AMOD - 1;
    m_out_valid = 1'b0; m_busy = 1'b0; m_rd = 1'b0; m_fault = 1'b0;
  endtask

  task automatic modelStep(input int cmd, input bit sel, input bit inc, input int spst,
                           input int r, input int inval, input bit ack, input int rdata);
    if (!m_busy) begin
      case (cmd)
        1:  m_ma = m_pc;
        2:  begin m_busy = 1'b1; m_rd = 1'b1; end
        3:  m_ir = m_md;
        4:  m_ma = m_md;
        5:  if (sel) m_ap = m_md; else m_a = m_md;
        6:  m_ma = m_ap;
        7:  m_ma = m_sp;
        8:  m_md = sel ? m_ap : m_a;
        9:  begin m_busy = 1'b1; m_rd = 1'b0; end
        10: if (sel) m_ap = r; else m_a = r;
        11: m_pc = m_md;
        12: m_a = inval;
        13: m_out = m_a;
        14: m_pc = m_ap;
        15: m_md = m_pc;
        default: ;
      endcase
      if (inc && cmd != 11 && cmd != 14) m_pc = (m_pc + 1) % AMOD;
      if (spst == 1) begin
        if (BOUNDS && m_sp == AMOD - 1) m_fault = 1'b1;
        else m_sp = (m_sp + 1) % AMOD;
      end else if (spst == 2) begin
        if (BOUNDS && m_sp == 0) m_fault = 1'b1;
        else m_sp = (m_sp + AMOD - 1) % AMOD;
      end
      m_out_valid = (cmd == 13);
    end else begin
      m_out_valid = 1'b0;
      if (ack) begin
        if (m_rd) m_md = rdata;
        else mem[m_ma] = m_md;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic checkModel();
    checkOutput("busy", 32'(o_busy), 32'(m_busy));
    checkOutput("mem_req", 32'(o_mem_req), 32'(m_busy));
    checkOutput("ir", 32'(o_ir), m_ir);
    checkOutput("a", 32'(o_a), m_a);
    checkOutput("md", 32'(o_md), m_md);
    checkOutput("out_data", 32'(o_out_data), m_out);
    checkOutput("out_valid", 32'(o_out_valid), 32'(m_out_valid));
    if (m_busy) begin
      checkOutput("mem_addr", 32'(o_mem_addr), m_ma);
      checkOutput("mem_we", 32'(o_mem_we), 32'(!m_rd));
      if (!m_rd) checkOutput("mem_wdata", 32'(o_mem_wdata), m_md);
    end
`ifdef EDULENT_SP_BOUNDS_EN
    checkOutput("sp_fault", 32'(o_sp_fault), 32'(m_fault));
`endif
  endtask

  // One clock: the memory responder decides ack, inputs are driven, then outputs are checked after the edge.
  task automatic applyStimulus(input int cmd, input bit sel, input bit inc, input int spst,
                               input int r, input int inval);
    bit ack;
    int rdata;
    if (o_mem_req === 1'b1) begin
      ack = (req_cycles >= ack_delay);
      req_cycles++;
    end else begin
      req_cycles = 0;
      if (rand_delay) ack_delay = int'($urandom_range(0, 3));
      ack = allow_spurious && ($urandom_range(0, 3) == 0);
    end
    rdata = ack ? mem[m_ma] : int'($urandom_range(0, AMOD - 1));
    i_transfer_cmd = 4'(cmd);
    i_sel_ap       = sel;
    i_inc_pc       = inc;
    i_inc_dec_sp   = 2'(spst);
    i_alu_result   = 8'(r);
    i_in_data      = 8'(inval);
    i_mem_ack      = ack;
    i_mem_rdata    = 8'(rdata);
    @(posedge i_clk);
    #1;
    modelStep(cmd, sel, inc, spst, r, inval, ack, rdata);
    checkModel();
  endtask

  task automatic doReset();
    i_rstn = 1'b0;
    i_transfer_cmd = '0; i_sel_ap = 1'b0; i_inc_pc = 1'b0; i_inc_dec_sp = '0;
    i_mem_ack = 1'b0;
    req_cycles = 0;
    #1;
    modelReset();
    checkModel();
    @(negedge i_clk);
    i_rstn = 1'b1;
  endtask

  // Junk command and strobes while waiting prove that a pending access blocks them.
  task automatic waitIdle(output int n);
    n = 0;
    while (o_busy === 1'b1 && n < 32) begin
      n++;
      applyStimulus(11, 1'b1, 1'b1, 1, 0, 0);
    end
  endtask

  task automatic loadA(input int v);
    applyStimulus(12, 1'b0, 1'b0, 0, 0, v);
  endtask

  task automatic loadMd(input int v);
    loadA(v);
    applyStimulus(8, 1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    int n;
    $display("[TB] edulent_datapath bench, SP bounds %0d", BOUNDS);
    for (int i = 0; i < AMOD; i++) mem[i] = int'($urandom_range(0, AMOD - 1));
    mem[0] = 8'h11;
    doReset();

    // Fetch: MA <- PC, read with PC increment, IR <- MD
    ack_delay = 3;
    applyStimulus(1, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus(2, 1'b0, 1'b1, 0, 0, 0);
    checkOutput("fetch_addr", 32'(o_mem_addr), 32'h00);
    waitIdle(n);
    checkOutput("fetch_busy_cycles", n, 4);
    applyStimulus(3, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("fetch_ir", 32'(o_ir), 32'h11);
    applyStimulus(15, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("fetch_pc", 32'(o_md), 32'h01);

    // Write: MA = 0x20, MD = 0x5A, ack one cycle after request
    loadMd(8'h20);
    applyStimulus(4, 1'b0, 1'b0, 0, 0, 0);
    loadMd(8'h5A);
    ack_delay = 1;
    applyStimulus(9, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("wr_req", 32'(o_mem_req), 32'h1);
    checkOutput("wr_we", 32'(o_mem_we), 32'h1);
    checkOutput("wr_addr", 32'(o_mem_addr), 32'h20);
    checkOutput("wr_wdata", 32'(o_mem_wdata), 32'h5A);
    waitIdle(n);
    checkOutput("wr_busy_cycles", n, 2);
    checkOutput("wr_req_after", 32'(o_mem_req), 32'h0);

    // PC load beats increment; PC wraps and MA takes the pre-increment value
    ack_delay = 0;
    loadMd(8'h40);
    applyStimulus(11, 1'b0, 1'b1, 0, 0, 0);
    applyStimulus(15, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("pc_load_wins", 32'(o_md), 32'h40);
    loadMd(8'hFF);
    applyStimulus(11, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus(1, 1'b0, 1'b1, 0, 0, 0);
    applyStimulus(15, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("pc_wrap", 32'(o_md), 32'h00);
    applyStimulus(2, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("ma_pre_inc", 32'(o_mem_addr), 32'hFF);
    waitIdle(n);

    // SP: walk down to 0 then decrement once more
    doReset();
    repeat (255) applyStimulus(0, 1'b0, 1'b0, 2, 0, 0);
    applyStimulus(7, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus(2, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("sp_zero", 32'(o_mem_addr), 32'h00);
    waitIdle(n);
    applyStimulus(0, 1'b0, 1'b0, 2, 0, 0);
    applyStimulus(7, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus(2, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("sp_underflow", 32'(o_mem_addr), BOUNDS ? 32'h00 : 32'hFF);
    waitIdle(n);
`ifdef EDULENT_SP_BOUNDS_EN
    repeat (3) applyStimulus(0, 1'b0, 1'b0, 1, 0, 0);
    checkOutput("sp_fault_sticky", 32'(o_sp_fault), 32'h1);
`endif
    doReset();

    // AP path, MA <- AP, then IN -> A -> OUT
    loadA(8'h12);
    applyStimulus(10, 1'b1, 1'b0, 0, 8'h33, 0);
    checkOutput("a_unchanged", 32'(o_a), 32'h12);
    applyStimulus(8, 1'b1, 1'b0, 0, 0, 0);
    checkOutput("ap_value", 32'(o_md), 32'h33);
    applyStimulus(6, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus(2, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("ma_from_ap", 32'(o_mem_addr), 32'h33);
    waitIdle(n);
    applyStimulus(12, 1'b0, 1'b0, 0, 0, 8'h7E);
    applyStimulus(13, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("out_data", 32'(o_out_data), 32'h7E);
    checkOutput("out_valid_pulse", 32'(o_out_valid), 32'h1);
    applyStimulus(0, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("out_valid_drop", 32'(o_out_valid), 32'h0);

    // Reset in the middle of a pending read
    ack_delay = 10;
    applyStimulus(2, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus(0, 1'b0, 1'b0, 0, 0, 0);
    #2;
    i_rstn = 1'b0;
    #1;
    checkOutput("rst_req_async", 32'(o_mem_req), 32'h0);
    checkOutput("rst_busy", 32'(o_busy), 32'h0);
    checkOutput("rst_md", 32'(o_md), 32'h00);
    doReset();
    ack_delay = 0;
    applyStimulus(15, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("rst_pc", 32'(o_md), 32'h00);
    applyStimulus(7, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus(2, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("rst_sp", 32'(o_mem_addr), 32'hFF);
    waitIdle(n);

    // Random traffic with random ack latency and stray acks while idle
    allow_spurious = 1'b1;
    rand_delay = 1'b1;
    repeat (1500)
      applyStimulus(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/edulent_datapath.md
Name: edulent_datapath

Overview:
- Register-transfer datapath for the EDULENT 8-bit CPU, directly downstream of the control unit.
- Each cycle it executes one 4-bit transfer command plus the PC increment and SP inc/dec strobes from the control unit.
- Holds MA, MD, IR, A, AP, PC, SP and OUT, and owns the req/ack memory port.
- Feeds IR back to the control unit as its opcode and A/MD to the ALU.

Parameters:
- DATA_W, 8, data and register width.
- ADDR_W, 8, memory address / PC / SP / MA width.
- SP_INIT, {ADDR_W{1'b1}}, SP reset value (stack grows down).
- PC_INIT, 0, PC reset value.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_transfer_cmd  in  4  transfer command 0x0-0xF
- i_sel_ap  in  1  selects AP (1) or A (0) for commands 5, 8, A
- i_inc_pc  in  1  PC += 1
- i_inc_dec_sp  in  2  01 = SP+1, 10 = SP-1, 00/11 = hold
- i_alu_result  in  DATA_W  ALU result R
- i_in_data  in  DATA_W  input port
- o_ir  out  DATA_W  instruction register, to control unit i_opcode
- o_a  out  DATA_W  accumulator, to ALU
- o_md  out  DATA_W  memory data register, to ALU
- o_out_data  out  DATA_W  output port register
- o_out_valid  out  1  one-cycle pulse when OUT is written
- o_busy  out  1  memory access pending; control unit must hold state while high
- o_mem_req  out  1  memory request
- o_mem_we  out  1  1 = write, 0 = read
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  write data
- i_mem_ack  in  1  memory completion; i_mem_rdata valid in the same cycle
- i_mem_rdata  in  DATA_W  read data

Behaviour:
- Reset values:
  - All registers and outputs 0, except PC = PC_INIT and SP = SP_INIT.
  - mem FSM in IDLE; o_busy = 0, o_mem_req = 0, o_out_valid = 0.
- Commands, all register updates at posedge; MA/MD/A/AP take the low ADDR_W/DATA_W bits as needed:
  - 0: nop
  - 1: MA <- PC
  - 2: memory read, MD <- M[MA]
  - 3: IR <- MD
  - 4: MA <- MD
  - 5: A or AP <- MD
  - 6: MA <- AP
  - 7: MA <- SP
  - 8: MD <- A or AP
  - 9: memory write, M[MA] <- MD
  - A: A or AP <- R
  - B: PC <- MD
  - C: A <- IN
  - D: OUT <- A, with o_out_valid pulsed for 1 cycle
  - E: PC <- AP
  - F: MD <- PC (zero-extended)
- Memory FSM has three states: IDLE, RD_WAIT, WR_WAIT.
  - IDLE + cmd 2: next cycle o_mem_req = 1, we = 0, addr = MA; go to RD_WAIT.
  - IDLE + cmd 9: next cycle o_mem_req = 1, we = 1, addr = MA, wdata = MD; go to WR_WAIT.
  - RD_WAIT + i_mem_ack: MD <- i_mem_rdata; return to IDLE.
  - WR_WAIT + i_mem_ack: return to IDLE.
  - o_busy = (state != IDLE). Minimum access is 2 cycles (issue + ack cycle).
  - req, we, addr and wdata stay stable until ack; ack while in IDLE is ignored.
- While o_busy:
  - i_transfer_cmd, i_inc_pc and i_inc_dec_sp are ignored.
  - The strobes accompanying cmd 2/9 are applied once, in the issue cycle.
- PC increment:
  - Wraps modulo 2^ADDR_W.
  - Same cycle as cmd B/E: the load wins and the increment is dropped.
- SP:
  - Wraps modulo 2^ADDR_W.
  - Cmd 7 with an SP strobe in the same cycle: MA gets the pre-update SP.
- Cmd 1 with i_inc_pc: MA gets the pre-increment PC.
- Reset asserted mid-access: FSM returns to IDLE and o_mem_req drops asynchronously; the in-flight result is discarded.

Optional Feature:
- EDULENT_SP_BOUNDS_EN defined:
  - Adds o_sp_fault (1 bit, sticky, cleared only by reset).
  - Sets on increment at all-ones or decrement at 0.
  - SP saturates instead of wrapping on those two events.
- Undefined: no port, SP wraps silently.

Decomposition:
- edulent_pkg holds:
  - transfer_cmd_t enum (CMD_NOP … CMD_MD_PC, 4-bit, values as above)
  - sp_op_t enum (SP_HOLD, SP_INC, SP_DEC)
  - mem_state_t enum
- One sub-module, edulent_mem_if: the IDLE/RD_WAIT/WR_WAIT handshake FSM, producing o_mem_* and o_busy, and returning read data with a load strobe.

Test Plan:
- Fetch sequence PC = 0x00, M[0x00] = 0x11, ack delay 3: cmd 1, then cmd 2 with inc_pc, then cmd 3 → MA = 0x00, o_busy high for 4 cycles, PC = 0x01 once, IR = 0x11.
- MD = 0x5A, MA = 0x20, cmd 9, ack after 1 cycle → exactly one req with we = 1, addr = 0x20, wdata = 0x5A; o_busy deasserts the cycle after ack.
- Cmd B with MD = 0x40 and i_inc_pc = 1 → PC = 0x40, not 0x41; cmd 1 with inc_pc from PC = 0xFF → MA = 0xFF, PC = 0x00.
- SP = 0x00, dec strobe → SP = 0xFF; with EDULENT_SP_BOUNDS_EN: SP stays 0x00 and o_sp_fault = 1 until reset.
- i_sel_ap = 1, R = 0x33, cmd A → AP = 0x33 with A unchanged; cmd 6 → MA = 0x33; IN = 0x7E, cmd C then cmd D → OUT = 0x7E with a 1-cycle o_out_valid.
- Cmd 2 issued, i_rstn pulsed low before ack → o_mem_req = 0 immediately, MD = 0, PC = PC_INIT, SP = SP_INIT, o_busy = 0.
